display_scan_controller: RTL and testbench
==========================================

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 100000, meaning clk cycles each digit is lit (legal minimum 2).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 4, meaning dead-time cycles between digits with all anodes off (0 = no dead time).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: high = scanning runs, low = display dark.
REQ-006 The block SHALL have port load_valid, input, 1 bit: a new 8-nibble value is offered.
REQ-007 The block SHALL have port load_data, input, 32 bits: offered value, nibble k = digit k.
REQ-008 The block SHALL have port load_ready, output, 1 bit: the block can accept a load.
REQ-009 The block SHALL have port blank_lz, input, 1 bit: high = suppress leading zeros.
REQ-010 The block SHALL have port dig_mask, input, 8 bits: per-digit enable, bit k = digit k.
REQ-011 The block SHALL have port digs, output, 32 bits: committed display value to the digit multiplexer.
REQ-012 The block SHALL have port counter, output, 3 bits: index of the digit currently scanned.
REQ-013 The block SHALL have port an_on, output, 8 bits: per-digit lit enables to the multiplexer.
REQ-014 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at frame wrap.

Function
REQ-015 The FSM SHALL have states IDLE, ON and BLANK; IDLE->ON when enable=1; ON->BLANK after PRESCALE cycles in ON, or ON->ON with the next digit if BLANK_CYCLES=0; BLANK->ON after BLANK_CYCLES cycles.
REQ-016 counter SHALL increment modulo 8 on every transition into a new digit's ON phase (7 wraps to 0); the digit period is PRESCALE+BLANK_CYCLES cycles.
REQ-017 frame_done SHALL pulse high for exactly one cycle on the cycle counter changes 7->0.
REQ-018 A load SHALL be accepted when load_valid=1 and load_ready=1 in the same cycle; load_ready SHALL drop the following cycle and remain low while a value is pending.
REQ-019 load_valid while load_ready=0 SHALL be ignored; the pending value is not overwritten.
REQ-020 A pending value SHALL be committed to digs on the 7->0 wrap cycle, so no frame shows mixed data; load_ready SHALL return high the cycle after the commit.
REQ-021 When the FSM is in IDLE, a pending value SHALL commit on the cycle after acceptance.
REQ-022 In ON, an_on SHALL equal dig_mask AND lz_mask, where lz_mask clears digits above the highest nonzero nibble of digs when blank_lz=1, digit 0 is never cleared, and lz_mask=8'hFF when blank_lz=0.
REQ-023 In BLANK and IDLE, an_on SHALL be 8'h00.
REQ-024 an_on SHALL be a registered output, one cycle behind state and digs changes.
REQ-025 enable falling in any state SHALL move the FSM to IDLE on the next edge, clearing counter, the prescaler and the blank counter; an_on SHALL be 0 the following cycle.
REQ-026 A commit and a new acceptance SHALL NOT occur in the same cycle; acceptance is gated by load_ready.

Reset
REQ-027 While reset=1, the block SHALL hold FSM=IDLE, digs=0, counter=0, an_on=0, frame_done=0, load_ready=1, no value pending, and prescaler/blank counters=0, independent of clk.
REQ-028 Reset asserted mid-scan or mid-load SHALL discard any pending value with no extra frame_done pulse, and scanning SHALL resume from digit 0 once reset is released with enable=1.

Structure
REQ-029 Package display_pkg SHALL hold the scan_state_t enum (IDLE, ON, BLANK) and the constant NUM_DIGITS=8.
REQ-030 Leading-zero mask generation SHALL be a combinational sub-module lz_mask_8 (in: digs, blank_lz; out: 8-bit mask).
REQ-031 Prescaler and blank counter widths SHALL be sized with $clog2 of their parameters.

Verification (benches use PRESCALE=4, BLANK_CYCLES=2)
REQ-032 Timing: enable=1 continuously -> counter steps every 6 cycles with an_on=0 for 2 cycles per step, and frame_done pulses every 48 cycles.
REQ-033 LZ blanking: load 32'h0000_1234 with blank_lz=1, dig_mask=8'hFF -> during ON, an_on=8'h0F masked to the current digit; load 32'h0 -> only digit 0 is enabled.
REQ-034 Frame-aligned commit: load 32'hDEAD_BEEF at counter=3 -> digs unchanged until the 7->0 wrap, load_ready low until then, a second load_valid while pending is ignored.
REQ-035 Disable: enable=0 at counter=5 -> counter=0 and an_on=0 within 2 cycles; a load in IDLE updates digs 1 cycle after acceptance.
REQ-036 Reset mid-scan: reset pulse at counter=6 with a value pending -> all outputs at reset values immediately, the pending value is lost, and the scan restarts at digit 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types for the 8-digit scan controller: FSM encoding, digit count, one-hot digit select.
package display_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIG_IDX_W  = $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ON    = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    function automatic logic [NUM_DIGITS-1:0] digit_sel(input logic [DIG_IDX_W-1:0] idx);
        digit_sel      = '0;
        digit_sel[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/lz_mask_8.sv
// Leading-zero digit mask: keeps digits up to the highest nonzero nibble, digit 0 always kept.
// Purely combinational; no flow control.
module lz_mask_8
    import display_pkg::*;
(
    input  logic [31:0] digs,
    input  logic        blank_lz,
    output logic [7:0]  mask
);

    logic seen;

    // Walk from the top digit down; once a nonzero nibble is seen every lower digit stays lit.
    always_comb begin
        mask = 8'h01;
        seen = 1'b0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            seen    = seen | (digs[4*k +: 4] != 4'h0);
            mask[k] = seen;
        end
        if (!blank_lz) begin
            mask = 8'hFF;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Scans 8 digits (PRESCALE lit + BLANK_CYCLES dark each); an_on lags state/digs by one cycle.
// Loads are held pending (load_ready low) and committed at the frame wrap, or next cycle when idle.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    input  logic        blank_lz,
    input  logic [7:0]  dig_mask,
    output logic [31:0] digs,
    output logic [2:0]  counter,
    output logic [7:0]  an_on,
    output logic        frame_done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    scan_state_t state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blank_q, blank_d;
    logic [2:0]    counter_q, counter_d;
    logic          frame_done_q, frame_done_d;
    logic [31:0]   digs_q, digs_d;
    logic [31:0]   pend_dat_q, pend_dat_d;
    logic          pend_q, pend_d;
    logic [7:0]    an_on_q, an_on_d;
    logic          step, wrap, accept, commit;
    logic [7:0]    lz_mask;

    lz_mask_8 u_lz_mask (
        .digs     (digs_q),
        .blank_lz (blank_lz),
        .mask     (lz_mask)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        blank_d   = blank_q;
        counter_d = counter_q;
        step      = 1'b0;
        if (!enable) begin
            state_d   = IDLE;
            presc_d   = '0;
            blank_d   = '0;
            counter_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ON;
                    presc_d = '0;
                end
                ON: begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (BLANK_CYCLES == 0) begin
                            step = 1'b1;
                        end else begin
                            state_d = BLANK;
                            blank_d = '0;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                BLANK: begin
                    if (blank_q == BLANK_LAST) begin
                        state_d = ON;
                        blank_d = '0;
                        step    = 1'b1;
                    end else begin
                        blank_d = blank_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (step) begin
            counter_d = counter_q + 3'd1;
        end
        wrap = step && (counter_q == 3'd7);
    end

    // pend_q set means load_ready is low, so accept and commit are mutually exclusive.
    always_comb begin
        accept       = load_valid && !pend_q;
        commit       = pend_q && ((state_q == IDLE) || wrap);
        pend_d       = pend_q;
        pend_dat_d   = pend_dat_q;
        digs_d       = digs_q;
        frame_done_d = wrap;
        if (commit) begin
            digs_d = pend_dat_q;
            pend_d = 1'b0;
        end
        if (accept) begin
            pend_dat_d = load_data;
            pend_d     = 1'b1;
        end
    end

    always_comb begin
        an_on_d = 8'h00;
        if (state_q == ON) begin
            an_on_d = digit_sel(counter_q) & dig_mask & lz_mask;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q      <= '0;
            blank_q      <= '0;
            counter_q    <= '0;
            frame_done_q <= 1'b0;
            digs_q       <= '0;
            pend_dat_q   <= '0;
            pend_q       <= 1'b0;
            an_on_q      <= '0;
        end else begin
            presc_q      <= presc_d;
            blank_q      <= blank_d;
            counter_q    <= counter_d;
            frame_done_q <= frame_done_d;
            digs_q       <= digs_d;
            pend_dat_q   <= pend_dat_d;
            pend_q       <= pend_d;
            an_on_q      <= an_on_d;
        end
    end

    assign load_ready = !pend_q;
    assign digs       = digs_q;
    assign counter    = counter_q;
    assign an_on      = an_on_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized + directed bench for display_scan_controller against a time-based reference model.
module tb_display_scan_controller;

    localparam int P     = 4;
    localparam int B     = 2;
    localparam int PER   = P + B;
    localparam int FRAME = 8 * PER;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic        blank_lz;
    logic [7:0]  dig_mask;
    logic [31:0] digs;
    logic [2:0]  counter;
    logic [7:0]  an_on;
    logic        frame_done;

    always #5 clk = ~clk;

    display_scan_controller #(
        .PRESCALE     (P),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .blank_lz   (blank_lz),
        .dig_mask   (dig_mask),
        .digs       (digs),
        .counter    (counter),
        .an_on      (an_on),
        .frame_done (frame_done)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: m_t is cycles since the scan started (-1 = idle).
    int          m_t;
    bit          m_pend;
    logic [31:0] m_pdat;
    logic [31:0] m_digs;
    logic [7:0]  m_an;
    bit          m_fd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] lz_ref(input logic [31:0] v, input bit blz);
        int hi;
        hi = 0;
        if (!blz) return 8'hFF;
        for (int k = 0; k < 8; k++) begin
            if (v[4*k +: 4] != 4'h0) hi = k;
        end
        return 8'((2 << hi) - 1);
    endfunction

    function automatic int m_cnt();
        return (m_t < 0) ? 0 : (m_t / PER) % 8;
    endfunction

    task automatic model_reset();
        m_t    = -1;
        m_pend = 0;
        m_pdat = '0;
        m_digs = '0;
        m_an   = '0;
        m_fd   = 0;
    endtask

    task automatic model_edge();
        int          nt;
        bit          cmt;
        bit          acc;
        logic [7:0]  an_next;
        an_next = 8'h00;
        if (m_t >= 0 && (m_t % PER) < P)
            an_next = 8'(1 << m_cnt()) & dig_mask & lz_ref(m_digs, blank_lz);
        nt   = !enable ? -1 : ((m_t < 0) ? 0 : m_t + 1);
        m_fd = enable && (m_t >= 0) && (nt % FRAME == 0);
        cmt  = m_pend && ((m_t < 0) || m_fd);
        acc  = load_valid && !m_pend;
        if (cmt) begin
            m_digs = m_pdat;
            m_pend = 0;
        end
        if (acc) begin
            m_pdat = load_data;
            m_pend = 1;
        end
        m_t  = nt;
        m_an = an_next;
    endtask

    task automatic check_all();
        check("counter",    32'(counter),    32'(m_cnt()));
        check("an_on",      32'(an_on),      32'(m_an));
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("load_ready", 32'(load_ready), 32'(!m_pend));
        check("digs",       digs,            m_digs);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        check_all();
    endtask

    // Reset asserted mid-cycle: outputs must clear without waiting for a clock edge.
    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_digit_start(input int target);
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (m_t >= 0 && m_cnt() == target && (m_t % PER) == 0) return;
            tick();
        end
        check("wait_digit", 32'(counter), 32'(target));
    endtask

    task automatic load(input logic [31:0] v);
        load_valid = 1'b1;
        load_data  = v;
        tick();
        load_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        blank_lz   = 1'b0;
        dig_mask   = 8'hFF;
        model_reset();
        #3;
        check_all();
        tick();
        tick();
        reset = 1'b0;

        // Idle load commits the cycle after acceptance.
        blank_lz = 1'b1;
        load(32'h0000_1234);
        tick();

        // Continuous scan with leading-zero blanking.
        enable = 1'b1;
        repeat (2 * FRAME + 5) tick();

        // All-zero value: only digit 0 may light.
        load(32'h0000_0000);
        repeat (FRAME + 10) tick();

        // Frame-aligned commit with an ignored second offer while pending.
        wait_digit_start(3);
        load(32'hDEAD_BEEF);
        load_valid = 1'b1;
        load_data  = 32'h1357_9BDF;
        repeat (3) tick();
        load_valid = 1'b0;
        repeat (FRAME) tick();

        // Disable mid-scan, then load while idle.
        wait_digit_start(5);
        tick();
        enable = 1'b0;
        repeat (3) tick();
        load(32'hCAFE_0000);
        tick();
        enable = 1'b1;
        repeat (10) tick();

        // Reset mid-scan with a pending value.
        wait_digit_start(6);
        load(32'h0BAD_F00D);
        tick();
        pulse_reset();
        repeat (FRAME + 10) tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            enable     = ($urandom_range(0, 299) != 0);
            load_valid = ($urandom_range(0, 3) == 0);
            load_data  = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 19) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 19) == 0) dig_mask = 8'($urandom);
            if ($urandom_range(0, 399) == 0) pulse_reset();
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
